// File: rtl/amt_commit_free_pkg.sv
// Shared sizing and walk-FSM encoding for the commit-side architectural map table.
package amt_commit_free_pkg;
  localparam int ARCH_REGS    = 32;
  localparam int ARCH_LOG     = 5;
  localparam int PHYS_LOG     = 7;
  localparam int COMMIT_WIDTH = 4;
  localparam int IDX_W        = ARCH_LOG - 2;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } walkState_t;
endpackage

// File: rtl/amt_commit_bypass.sv
// Retire-group resolution: previous tag per slot (with older-slot bypass) and
// the final per-register AMT write, youngest slot winning.
module amt_commit_bypass
  import amt_commit_free_pkg::*;
(
  input  logic [COMMIT_WIDTH-1:0]               commitValid,
  input  logic [COMMIT_WIDTH-1:0][ARCH_LOG-1:0] logDest,
  input  logic [COMMIT_WIDTH-1:0][PHYS_LOG-1:0] phyDest,
  input  logic [COMMIT_WIDTH-1:0][PHYS_LOG-1:0] amtRead,
  output logic [COMMIT_WIDTH-1:0][PHYS_LOG-1:0] oldTag,
  output logic [ARCH_REGS-1:0]                  wrEn,
  output logic [ARCH_REGS-1:0][PHYS_LOG-1:0]    wrData
);

  // Ascending scan over older slots leaves the youngest matching one in place.
  always_comb begin
    oldTag = '0;
    for (int n = 0; n < COMMIT_WIDTH; n++) begin
      if (commitValid[n]) begin
        oldTag[n] = amtRead[n];
        for (int m = 0; m < COMMIT_WIDTH; m++) begin
          if (m < n && commitValid[m] && logDest[m] == logDest[n])
            oldTag[n] = phyDest[m];
        end
      end
    end
  end

  always_comb begin
    wrEn   = '0;
    wrData = '0;
    for (int r = 0; r < ARCH_REGS; r++) begin
      for (int n = 0; n < COMMIT_WIDTH; n++) begin
        if (commitValid[n] && logDest[n] == ARCH_LOG'(r)) begin
          wrEn[r]   = 1'b1;
          wrData[r] = phyDest[n];
        end
      end
    end
  end

endmodule

// File: rtl/amt_commit_free.sv
// Commit-side AMT: releases superseded physical tags to the free list and
// streams the whole table to the rename map on recovery.
//
// state | meaning
// IDLE  | accepting commits, no walk in progress
// WALK  | emitting one 4-entry restore beat per cycle, commits blocked
module amt_commit_free
  import amt_commit_free_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                commitValid0_i,
  input  logic                commitValid1_i,
  input  logic                commitValid2_i,
  input  logic                commitValid3_i,
  input  logic [ARCH_LOG-1:0] commitLogDest0_i,
  input  logic [ARCH_LOG-1:0] commitLogDest1_i,
  input  logic [ARCH_LOG-1:0] commitLogDest2_i,
  input  logic [ARCH_LOG-1:0] commitLogDest3_i,
  input  logic [PHYS_LOG-1:0] commitPhyDest0_i,
  input  logic [PHYS_LOG-1:0] commitPhyDest1_i,
  input  logic [PHYS_LOG-1:0] commitPhyDest2_i,
  input  logic [PHYS_LOG-1:0] commitPhyDest3_i,
  input  logic                recoverFlag_i,
  output logic                freeValid0_o,
  output logic                freeValid1_o,
  output logic                freeValid2_o,
  output logic                freeValid3_o,
  output logic [PHYS_LOG-1:0] freeReg0_o,
  output logic [PHYS_LOG-1:0] freeReg1_o,
  output logic [PHYS_LOG-1:0] freeReg2_o,
  output logic [PHYS_LOG-1:0] freeReg3_o,
  output logic                restoreValid_o,
  output logic [IDX_W-1:0]    restoreIdx_o,
  output logic [PHYS_LOG-1:0] restoreMap0_o,
  output logic [PHYS_LOG-1:0] restoreMap1_o,
  output logic [PHYS_LOG-1:0] restoreMap2_o,
  output logic [PHYS_LOG-1:0] restoreMap3_o,
  output logic                recoverBusy_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARCH_REGS / COMMIT_WIDTH - 1);

  logic [PHYS_LOG-1:0] amt [ARCH_REGS];
  walkState_t          state, nextState;
  logic [IDX_W-1:0]    idx, idxNext;
  logic                beatValid;

  logic [COMMIT_WIDTH-1:0]               commitOk;
  logic [COMMIT_WIDTH-1:0][ARCH_LOG-1:0] logDest;
  logic [COMMIT_WIDTH-1:0][PHYS_LOG-1:0] phyDest;
  logic [COMMIT_WIDTH-1:0][PHYS_LOG-1:0] amtRead;
  logic [COMMIT_WIDTH-1:0][PHYS_LOG-1:0] oldTag;
  logic [ARCH_REGS-1:0]                  wrEn;
  logic [ARCH_REGS-1:0][PHYS_LOG-1:0]    wrData;
  logic [COMMIT_WIDTH-1:0]               freeValid;
  logic [COMMIT_WIDTH-1:0][PHYS_LOG-1:0] freeReg;
  logic [COMMIT_WIDTH-1:0][PHYS_LOG-1:0] restoreMap;

  assign recoverBusy_o = (state == WALK) || restoreValid_o;

  // Commits arriving during a walk violate the retire protocol and are dropped.
  assign commitOk = {commitValid3_i, commitValid2_i, commitValid1_i, commitValid0_i}
                    & {COMMIT_WIDTH{~recoverBusy_o}};
  assign logDest  = {commitLogDest3_i, commitLogDest2_i, commitLogDest1_i, commitLogDest0_i};
  assign phyDest  = {commitPhyDest3_i, commitPhyDest2_i, commitPhyDest1_i, commitPhyDest0_i};

  always_comb begin
    for (int n = 0; n < COMMIT_WIDTH; n++) amtRead[n] = amt[logDest[n]];
  end

  amt_commit_bypass uBypass (
    .commitValid (commitOk),
    .logDest     (logDest),
    .phyDest     (phyDest),
    .amtRead     (amtRead),
    .oldTag      (oldTag),
    .wrEn        (wrEn),
    .wrData      (wrData)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= nextState;
      idx   <= idxNext;
    end
  end

  always_comb begin
    nextState = state;
    idxNext   = idx;
    beatValid = 1'b0;
    case (state)
      IDLE: begin
        if (recoverFlag_i) begin
          nextState = WALK;
          idxNext   = '0;
        end
      end
      WALK: begin
        beatValid = 1'b1;
        if (recoverFlag_i) begin
          idxNext = '0;
        end else if (idx == LAST_IDX) begin
          nextState = IDLE;
          idxNext   = '0;
        end else begin
          idxNext = idx + 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) amt[i] <= PHYS_LOG'(i);
      freeValid      <= '0;
      freeReg        <= '0;
      restoreValid_o <= 1'b0;
      restoreIdx_o   <= '0;
      restoreMap     <= '0;
    end else begin
      for (int r = 0; r < ARCH_REGS; r++) begin
        if (wrEn[r]) amt[r] <= wrData[r];
      end
      freeValid      <= commitOk;
      freeReg        <= oldTag;
      restoreValid_o <= beatValid;
      restoreIdx_o   <= beatValid ? idx : '0;
      for (int k = 0; k < COMMIT_WIDTH; k++)
        restoreMap[k] <= beatValid ? amt[{idx, 2'(k)}] : '0;
    end
  end

  assign {freeValid3_o, freeValid2_o, freeValid1_o, freeValid0_o} = freeValid;
  assign freeReg0_o    = freeReg[0];
  assign freeReg1_o    = freeReg[1];
  assign freeReg2_o    = freeReg[2];
  assign freeReg3_o    = freeReg[3];
  assign restoreMap0_o = restoreMap[0];
  assign restoreMap1_o = restoreMap[1];
  assign restoreMap2_o = restoreMap[2];
  assign restoreMap3_o = restoreMap[3];

endmodule

// File: tb/tb_amt_commit_free.sv
// Directed bench for amt_commit_free: releases, intra-group bypass, walk, restart, reset.
module tb_amt_commit_free;
  import amt_commit_free_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [3:0]      cV;
  logic [3:0][4:0] cL;
  logic [3:0][6:0] cP;
  logic            recoverFlag;

  logic       freeValid0_o, freeValid1_o, freeValid2_o, freeValid3_o;
  logic [6:0] freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o;
  logic       restoreValid_o;
  logic [2:0] restoreIdx_o;
  logic [6:0] restoreMap0_o, restoreMap1_o, restoreMap2_o, restoreMap3_o;
  logic       recoverBusy_o;

  int total = 0;
  int bad = 0;
  int protoHits = 0;
  logic [6:0] expAmt [32];

  amt_commit_free dut (
    .clk(clk), .reset(reset),
    .commitValid0_i(cV[0]), .commitValid1_i(cV[1]),
    .commitValid2_i(cV[2]), .commitValid3_i(cV[3]),
    .commitLogDest0_i(cL[0]), .commitLogDest1_i(cL[1]),
    .commitLogDest2_i(cL[2]), .commitLogDest3_i(cL[3]),
    .commitPhyDest0_i(cP[0]), .commitPhyDest1_i(cP[1]),
    .commitPhyDest2_i(cP[2]), .commitPhyDest3_i(cP[3]),
    .recoverFlag_i(recoverFlag),
    .freeValid0_o(freeValid0_o), .freeValid1_o(freeValid1_o),
    .freeValid2_o(freeValid2_o), .freeValid3_o(freeValid3_o),
    .freeReg0_o(freeReg0_o), .freeReg1_o(freeReg1_o),
    .freeReg2_o(freeReg2_o), .freeReg3_o(freeReg3_o),
    .restoreValid_o(restoreValid_o), .restoreIdx_o(restoreIdx_o),
    .restoreMap0_o(restoreMap0_o), .restoreMap1_o(restoreMap1_o),
    .restoreMap2_o(restoreMap2_o), .restoreMap3_o(restoreMap3_o),
    .recoverBusy_o(recoverBusy_o)
  );

  always #5 clk = ~clk;

  wire [3:0]  freeV    = {freeValid3_o, freeValid2_o, freeValid1_o, freeValid0_o};
  wire [27:0] freeRegs = {freeReg3_o, freeReg2_o, freeReg1_o, freeReg0_o};
  wire [27:0] maps     = {restoreMap3_o, restoreMap2_o, restoreMap1_o, restoreMap0_o};

  // Retire-protocol watchdog: a commit while the walk is busy is a bench-side violation.
  always @(posedge clk) begin
    if (reset === 1'b0 && recoverBusy_o === 1'b1 && (|cV)) begin
      protoHits++;
      $display("note: protocol violation, commit while recoverBusy at %0t", $time);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_commits();
    cV = '0;
    cL = '0;
    cP = '0;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) expAmt[i] = 7'(i);
  endtask

  // Entered just after the edge that put the FSM into WALK with idx 0.
  task automatic run_walk_check(input string tag);
    logic [27:0] expMaps;
    total++;
    if (recoverBusy_o !== 1'b1) begin
      bad++;
      $display("FAIL %s_busy_start got=%0b exp=1", tag, recoverBusy_o);
    end
    for (int b = 0; b < 8; b++) begin
      step();
      expMaps = {expAmt[4*b+3], expAmt[4*b+2], expAmt[4*b+1], expAmt[4*b]};
      total++;
      if (restoreValid_o !== 1'b1 || restoreIdx_o !== 3'(b) || maps !== expMaps
          || recoverBusy_o !== 1'b1) begin
        bad++;
        $display("FAIL %s_beat%0d got v=%0b idx=%0d maps=%h busy=%0b exp v=1 idx=%0d maps=%h busy=1",
                 tag, b, restoreValid_o, restoreIdx_o, maps, recoverBusy_o, b, expMaps);
      end
    end
    step();
    total++;
    if (restoreValid_o !== 1'b0 || recoverBusy_o !== 1'b0 || restoreIdx_o !== 3'd0 || maps !== 28'd0) begin
      bad++;
      $display("FAIL %s_end got v=%0b busy=%0b idx=%0d maps=%h exp all 0",
               tag, restoreValid_o, recoverBusy_o, restoreIdx_o, maps);
    end
  endtask

  task automatic start_walk();
    recoverFlag = 1'b1;
    step();
    recoverFlag = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    recoverFlag = 1'b0;
    clear_commits();
    reset_model();
    #12;
    total++;
    if (freeV !== 4'd0 || freeRegs !== 28'd0) begin
      bad++;
      $display("FAIL reset_free got v=%b regs=%h exp 0", freeV, freeRegs);
    end
    total++;
    if (restoreValid_o !== 1'b0 || restoreIdx_o !== 3'd0 || maps !== 28'd0 || recoverBusy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_restore got v=%0b idx=%0d maps=%h busy=%0b exp 0",
               restoreValid_o, restoreIdx_o, maps, recoverBusy_o);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_walk_identity();
    start_walk();
    total++;
    if (restoreValid_o !== 1'b0) begin
      bad++;
      $display("FAIL walk_first_cycle_valid got=%0b exp=0", restoreValid_o);
    end
    run_walk_check("walk_identity");
  endtask

  task automatic test_single_commit();
    cV = 4'b0001; cL[0] = 5'd5; cP[0] = 7'd40;
    step();
    clear_commits();
    total++;
    if (freeV !== 4'b0001 || freeRegs !== {7'd0, 7'd0, 7'd0, 7'd5}) begin
      bad++;
      $display("FAIL single_release got v=%b regs=%h exp v=0001 reg0=5", freeV, freeRegs);
    end
    step();
    total++;
    if (freeV !== 4'd0 || freeRegs !== 28'd0) begin
      bad++;
      $display("FAIL single_idle got v=%b regs=%h exp 0", freeV, freeRegs);
    end
    cV = 4'b0001; cL[0] = 5'd5; cP[0] = 7'd41;
    step();
    clear_commits();
    total++;
    if (freeV !== 4'b0001 || freeReg0_o !== 7'd40) begin
      bad++;
      $display("FAIL single_rerelease got v=%b reg0=%0d exp v=0001 reg0=40", freeV, freeReg0_o);
    end
    expAmt[5] = 7'd41;
  endtask

  task automatic test_bypass();
    cV = 4'b0111;
    cL[0] = 5'd3; cP[0] = 7'd50;
    cL[1] = 5'd7; cP[1] = 7'd60;
    cL[2] = 5'd3; cP[2] = 7'd51;
    step();
    clear_commits();
    total++;
    if (freeV !== 4'b0111 || freeRegs !== {7'd0, 7'd50, 7'd7, 7'd3}) begin
      bad++;
      $display("FAIL bypass_release got v=%b regs=%h exp v=0111 regs=3,7,50,0", freeV, freeRegs);
    end
    expAmt[3] = 7'd51;
    expAmt[7] = 7'd60;
    step();
    start_walk();
    run_walk_check("bypass_walk");
  endtask

  task automatic test_commit_with_recover();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    reset_model();
    step();
    cV = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      cL[n] = 5'(n);
      cP[n] = 7'(80 + n);
    end
    recoverFlag = 1'b1;
    step();
    recoverFlag = 1'b0;
    clear_commits();
    total++;
    if (freeV !== 4'b1111 || freeRegs !== {7'd3, 7'd2, 7'd1, 7'd0}) begin
      bad++;
      $display("FAIL recover_commit_release got v=%b regs=%h exp v=1111 regs=0,1,2,3", freeV, freeRegs);
    end
    for (int n = 0; n < 4; n++) expAmt[n] = 7'(80 + n);
    run_walk_check("recover_commit_walk");
  endtask

  task automatic test_restart();
    start_walk();
    for (int b = 0; b < 5; b++) begin
      step();
      total++;
      if (restoreValid_o !== 1'b1 || restoreIdx_o !== 3'(b)) begin
        bad++;
        $display("FAIL restart_pre_beat%0d got v=%0b idx=%0d exp v=1 idx=%0d",
                 b, restoreValid_o, restoreIdx_o, b);
      end
    end
    recoverFlag = 1'b1;
    step();
    recoverFlag = 1'b0;
    total++;
    if (restoreValid_o !== 1'b1 || restoreIdx_o !== 3'd5) begin
      bad++;
      $display("FAIL restart_flag_beat got v=%0b idx=%0d exp v=1 idx=5", restoreValid_o, restoreIdx_o);
    end
    run_walk_check("restart_walk");
  endtask

  task automatic test_reset_midwalk();
    start_walk();
    step(); step(); step();
    total++;
    if (restoreIdx_o !== 3'd2) begin
      bad++;
      $display("FAIL midwalk_pre got idx=%0d exp=2", restoreIdx_o);
    end
    reset = 1'b1;
    #1;
    total++;
    if (restoreValid_o !== 1'b0 || restoreIdx_o !== 3'd0 || maps !== 28'd0
        || recoverBusy_o !== 1'b0 || freeV !== 4'd0 || freeRegs !== 28'd0) begin
      bad++;
      $display("FAIL midwalk_reset got v=%0b idx=%0d maps=%h busy=%0b fv=%b fr=%h exp all 0",
               restoreValid_o, restoreIdx_o, maps, recoverBusy_o, freeV, freeRegs);
    end
    reset_model();
    #2;
    reset = 1'b0;
    step();
    total++;
    if (restoreValid_o !== 1'b0 || recoverBusy_o !== 1'b0) begin
      bad++;
      $display("FAIL midwalk_after got v=%0b busy=%0b exp 0", restoreValid_o, recoverBusy_o);
    end
    start_walk();
    run_walk_check("midwalk_identity");
  endtask

  task automatic test_protocol_violation();
    int hitsBefore;
    int waited;
    hitsBefore = protoHits;
    start_walk();
    cV = 4'b0001; cL[0] = 5'd9; cP[0] = 7'd90;
    step();
    clear_commits();
    total++;
    if (freeV !== 4'd0 || freeReg0_o !== 7'd0) begin
      bad++;
      $display("FAIL proto_no_release got v=%b reg0=%0d exp 0", freeV, freeReg0_o);
    end
    total++;
    if (protoHits !== hitsBefore + 1) begin
      bad++;
      $display("FAIL proto_assert got hits=%0d exp=%0d", protoHits - hitsBefore, 1);
    end
    waited = 0;
    while (recoverBusy_o === 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    total++;
    if (recoverBusy_o !== 1'b0) begin
      bad++;
      $display("FAIL proto_busy_timeout got busy=%0b after %0d cycles exp 0", recoverBusy_o, waited);
    end
    step();
    start_walk();
    run_walk_check("proto_amt_unchanged");
  endtask

  initial begin
    test_reset();
    test_walk_identity();
    test_single_commit();
    test_bypass();
    test_commit_with_recover();
    test_restart();
    test_reset_midwalk();
    test_protocol_violation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
